// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster timing bundle between the timing generator
// and its consumers. Line-compare signals exist only with VGA_LINE_IRQ_EN.
interface vga_timing_gen_if;
  logic        enable;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic        vblank_start;
  logic [15:0] frame_count;
`ifdef VGA_LINE_IRQ_EN
  logic [9:0]  line_cmp;
  logic        line_irq;

  modport master (
    input  enable, line_cmp,
    output DrawX, DrawY, blank, hs, vs,
    output frame_start, vblank_start,
    output frame_count, line_irq
  );

  modport slave (
    output enable, line_cmp,
    input  DrawX, DrawY, blank, hs, vs,
    input  frame_start, vblank_start,
    input  frame_count, line_irq
  );
`else
  modport master (
    input  enable,
    output DrawX, DrawY, blank, hs, vs,
    output frame_start, vblank_start,
    output frame_count
  );

  modport slave (
    output enable,
    input  DrawX, DrawY, blank, hs, vs,
    input  frame_start, vblank_start,
    input  frame_count
  );
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/blank decode and frame events.
// Optional line-compare interrupt is built when VGA_LINE_IRQ_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input logic               vga_clk,
  input logic               reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
      $error("vga_timing_gen: totals exceed 10-bit counters");
    end
  endgenerate

  localparam logic [9:0]  H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  h_nxt;
  logic [9:0]  v_nxt;
  logic        h_wrap;
  logic [10:0] h_ext;
  logic [10:0] v_ext;
  logic        blank_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        fs_nxt;
  logic        vb_nxt;
  logic        blank_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;
  logic        vb_q;
  logic [15:0] fc_q;

  // Next raster position: h wraps each line, v steps on h wrap.
  always_comb begin
    h_wrap = (h_cnt == H_MAX);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  // Decode the next position so every output lands with the counters.
  always_comb begin
    h_ext     = {1'b0, h_nxt};
    v_ext     = {1'b0, v_nxt};
    blank_nxt = (h_ext < H_ACT) && (v_ext < V_ACT);
    hs_nxt    = (h_ext >= HS_BEG && h_ext < HS_END)
              ? SYNC_POL : ~SYNC_POL;
    vs_nxt    = (v_ext >= VS_BEG && v_ext < VS_END)
              ? SYNC_POL : ~SYNC_POL;
    fs_nxt    = (h_nxt == 10'd0) && (v_nxt == 10'd0);
    vb_nxt    = (h_nxt == 10'd0) && (v_ext == V_ACT);
  end

  // Counters and decoded outputs advance together; pulses self-clear.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt   <= H_MAX;
      v_cnt   <= V_MAX;
      blank_q <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      fs_q    <= 1'b0;
      vb_q    <= 1'b0;
      fc_q    <= 16'd0;
    end else begin
      fs_q <= vga.enable & fs_nxt;
      vb_q <= vga.enable & vb_nxt;
      if (vga.enable) begin
        h_cnt   <= h_nxt;
        v_cnt   <= v_nxt;
        blank_q <= blank_nxt;
        hs_q    <= hs_nxt;
        vs_q    <= vs_nxt;
        if (fs_nxt) begin
          fc_q <= fc_q + 16'd1;
        end
      end
    end
  end

`ifdef VGA_LINE_IRQ_EN
  logic irq_nxt;
  logic irq_q;

  // A compare value beyond the frame can never match v_nxt.
  always_comb begin
    irq_nxt = (h_nxt == 10'd0) && (v_nxt == vga.line_cmp);
  end

  // Line interrupt pulse, same timing as frame_start.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= vga.enable & irq_nxt;
    end
  end

  assign vga.line_irq = irq_q;
`endif

  assign vga.DrawX        = h_cnt;
  assign vga.DrawY        = v_cnt;
  assign vga.blank        = blank_q;
  assign vga.hs           = hs_q;
  assign vga.vs           = vs_q;
  assign vga.frame_start  = fs_q;
  assign vga.vblank_start = vb_q;
  assign vga.frame_count  = fc_q;

endmodule
